// File: rtl/bist_pkg.sv
// Shared BIST constants: analyzer FSM states, SISR defaults and the
// pattern generator's LFSR constants.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } sra_state_e;

  localparam logic [15:0] SISR_POLY_DEF = 16'h1021;
  localparam logic [15:0] SISR_SEED_DEF = 16'h0000;

  localparam logic [15:0] LFSR_POLY_DEF = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // Width needed to count 0..limit-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/scan_response_analyzer_sisr.sv
// Serial-input signature register: shifts left, folding the incoming
// scan bit into the feedback taps.
module sisr
  import bist_pkg::*;
#(
  parameter int unsigned          SIG_W = 16,
  parameter logic [SIG_W-1:0]     POLY  = SIG_W'(SISR_POLY_DEF),
  parameter logic [SIG_W-1:0]     SEED  = SIG_W'(SISR_SEED_DEF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] q
);

  logic [SIG_W-1:0] sig_q, sig_d;

  // Next signature: load has priority over a shift.
  always_comb begin
    sig_d = sig_q;
    if (load) begin
      sig_d = SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ ((sig_q[SIG_W-1] ^ din) ? POLY : '0);
    end
  end

  // Signature register with asynchronous reset to the seed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign q = sig_q;

endmodule

// File: rtl/scan_response_analyzer.sv
// Scan response analyzer: compacts CHAIN_LEN x NUM_PAT scan-out bits into
// a signature and compares it against GOLDEN at the end of a session.
module scan_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned      SIG_W     = 16,
  parameter logic [SIG_W-1:0] POLY      = SIG_W'(SISR_POLY_DEF),
  parameter logic [SIG_W-1:0] SEED      = SIG_W'(SISR_SEED_DEF),
  parameter int unsigned      CHAIN_LEN = 32,
  parameter int unsigned      NUM_PAT   = 1000,
  parameter logic [SIG_W-1:0] GOLDEN    = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             shift_en,
  input  logic             scan_bit,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             proto_err,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned BIT_W = cnt_width(CHAIN_LEN);
  localparam int unsigned PAT_W = cnt_width(NUM_PAT);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PAT - 1);

  sra_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0] pat_cnt_q, pat_cnt_d;
  logic             pass_q, pass_d;
  logic             perr_q, perr_d;
  logic             sisr_load;
  logic             sisr_en;

  sisr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_sisr (
    .clock (clock),
    .reset (reset),
    .load  (sisr_load),
    .en    (sisr_en),
    .din   (scan_bit),
    .q     (signature)
  );

  // Next-state, counter, compare and protocol-check logic.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pat_cnt_d = pat_cnt_q;
    pass_d    = pass_q;
    perr_d    = perr_q;
    sisr_load = 1'b0;
    sisr_en   = 1'b0;
    if (start) begin
      // Start wins over shift_en in every state; a coincident bit is dropped.
      state_d   = ST_RUN;
      bit_cnt_d = '0;
      pat_cnt_d = '0;
      pass_d    = 1'b0;
      perr_d    = 1'b0;
      sisr_load = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (shift_en) begin
            sisr_en = 1'b1;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
              if (pat_cnt_q == PAT_LAST) begin
                pat_cnt_d = '0;
                state_d   = ST_CHECK;
              end else begin
                pat_cnt_d = pat_cnt_q + 1'b1;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          pass_d  = (signature == GOLDEN);
          state_d = ST_DONE;
          if (shift_en) perr_d = 1'b1;
        end
        default: begin
          if (shift_en) perr_d = 1'b1;
        end
      endcase
    end
  end

  // State, counters and flags with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      pat_cnt_q <= '0;
      pass_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      pass_q    <= pass_d;
      perr_q    <= perr_d;
    end
  end

  assign busy      = (state_q == ST_RUN) || (state_q == ST_CHECK);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign proto_err = perr_q;

endmodule
